muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle HI/LO unit for MULT/MULTU/DIV/DIVU, with MTHI/MTLO writes into the same HI/LO registers.
//  Accepts one op at a time and sequences a pipelined multiply or a 32-step restoring divide.
//  Owns the architectural HI/LO registers.
//  Sits beside the main ALU. Control raises a stall while busy=1 and MFHI/MFLO is pending.
// PARAMETERS
//  MUL_LAT   3   multiply latency in cycles, legal 1..8; models a retimed multiplier array
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  start         in   1   op request, sampled only when busy=0
//  op            in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a             in   32  multiplicand / dividend
//  b             in   32  multiplier / divisor
//  mthi          in   1   write wdata into HI (idle only)
//  mtlo          in   1   write wdata into LO (idle only)
//  wdata         in   32  MTHI/MTLO data
//  busy          out  1   op in flight
//  done          out  1   one-cycle pulse: new HI/LO visible this cycle
//  div_by_zero   out  1   sticky flag, set by a DIV/DIVU with b==0, cleared by the next accepted start
//  hi            out  32  HI register
//  lo            out  32  LO register
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0. An in-flight op is discarded.
//  States: IDLE -> MUL (count MUL_LAT) -> IDLE; IDLE -> DIV (32 iterations) -> FIX -> IDLE; IDLE -> DZ -> IDLE.
//  Accept: start=1 && busy=0 at edge E0. Operands are latched, busy=1 from E0, and div_by_zero is cleared.
//  MUL: at edge E(MUL_LAT), {hi,lo} <= 64-bit product. Signed for MULT, unsigned for MULTU.
//  DIV, b!=0:
//   - E0 latches |a| and |b| (signed op) or raw values (unsigned op).
//   - E1..E32: one restoring step per edge, MSB first.
//   - E33 (FIX): negate the quotient if sign(a)!=sign(b); the remainder takes sign(a); load lo=quotient, hi=remainder.
//  DIV overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0 (natural 32-bit wrap, no flag).
//  DIV, b==0: DZ state. At E1: lo=32'hFFFFFFFF, hi=a, div_by_zero=1.
//  Completion: in the cycle after the HI/LO-loading edge, done=1 and busy=0.
//   - Back-to-back: start may be accepted in that same done cycle.
//  Latencies (start edge to done cycle): MUL = MUL_LAT, DIV = 33, DZ = 1.
//  start while busy=1: ignored, no queueing; the requester must hold or reissue.
//  mthi/mtlo while busy=1: ignored.
//  mthi/mtlo while idle: written at the next edge, with no done pulse.
//  start and mthi/mtlo in the same idle cycle: start wins; the mt write is dropped.
//  hi/lo are stable, holding the previous result, throughout busy. They change only at a completion edge or an MT write.
//  done is never asserted for two consecutive cycles from a single op.
//  op and operands are don't-care except when start is accepted.
// STRUCTURE
//  Shared header mdu_defs.vh:
//   - op encodings MDU_MULTU/MULT/DIVU/DIV
//   - state localparams IDLE/MUL/DIV/FIX/DZ
//   - DIV_STEPS=32
//  One sub-module: div_step_unit, combinational.
//   - Inputs: {rem,quo}, divisor.
//   - Output: the next {rem,quo} of one restoring step, via trial subtract and a conditional restore.
//  Top level holds the FSM, step counter (6 bits), MUL_LAT-deep product pipeline, sign flags, and HI/LO.
// TESTING
//  1. MULTU a=FFFFFFFF b=FFFFFFFF, MUL_LAT=3 -> done 3 cycles after the start edge; hi=FFFFFFFE, lo=00000001.
//  2. MULT a=-3 b=7 -> hi=FFFFFFFF, lo=FFFFFFEB. MULTU with the same operands -> hi=00000006, lo=FFFFFFEB.
//  3. DIV a=-7 b=2 -> done at 33; lo=FFFFFFFD, hi=FFFFFFFF.
//     DIVU a=-7 (FFFFFFF9) b=2 -> lo=7FFFFFFC, hi=1.
//  4. DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
//     DIVU a=5 b=0 -> done at 1; lo=FFFFFFFF, hi=5, div_by_zero=1.
//     The next start clears div_by_zero.
//  5. start, mthi, and a second start while busy -> all ignored; the first op's result is intact.
//     mtlo while idle -> lo=wdata at the next edge, done=0.
//     start and mthi in the same cycle -> hi not written.
//  6. rst at DIV step 10 -> next cycle busy=0, done=0, hi=lo=0, and no later done.
//     A fresh MULT then completes correctly.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM states,
// divide step count and small arithmetic helpers.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mduOp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DZ
  } mduState_e;

  localparam int DIV_STEPS = 32;

  function automatic logic [31:0] absVal(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

  // Extending both operands to 64 bits makes the low 64 bits of the product exact for either signedness.
  function automatic logic [63:0] mulProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic isSigned);
    logic [63:0] aExt;
    logic [63:0] bExt;
    aExt = isSigned ? {{32{a[31]}}, a} : {32'b0, a};
    bExt = isSigned ? {{32{b[31]}}, b} : {32'b0, b};
    return aExt * bExt;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between control and the HI/LO sequencer.
interface muldiv_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, mthi, mtlo, wdata,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, mthi, mtlo, wdata,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_sequencer_div_step_unit.sv
// One combinational restoring-divide step on {remainder, quotient}, shifting MSB first.
module div_step_unit (
  input  logic [63:0] remQuo_i,
  input  logic [31:0] divisor_i,
  output logic [63:0] remQuo_o
);

  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;

  assign shifted = {remQuo_i[63:32], remQuo_i[31]};
  assign fits    = shifted >= {1'b0, divisor_i};
  // When the trial subtract succeeds the result is below the divisor, so 32 bits suffice.
  assign diff    = shifted[31:0] - divisor_i;

  assign remQuo_o = fits ? {diff, remQuo_i[30:0], 1'b1}
                         : {shifted[31:0], remQuo_i[30:0], 1'b0};

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO unit: pipelined multiply, 32-step restoring divide, divide-by-zero shortcut and MTHI/MTLO writes.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);

  mduState_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] remQuo_q, remQuo_d;
  logic [31:0] divisor_q, divisor_d;
  logic        negQuo_q, negQuo_d;
  logic        negRem_q, negRem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic [63:0] prodPipe_q [MUL_LAT];
  logic [63:0] stepOut;
  logic        divSigned;

  assign divSigned = (bus.op == OP_DIV);

  div_step_unit u_step (
    .remQuo_i  (remQuo_q),
    .divisor_i (divisor_q),
    .remQuo_o  (stepOut)
  );

  // The product enters stage 0 on the accept edge and ripples down; only the accepted op's value is consumed.
  always_ff @(posedge clk) begin
    prodPipe_q[0] <= mulProduct(bus.a, bus.b, bus.op == OP_MULT);
    for (int i = 1; i < MUL_LAT; i++) prodPipe_q[i] <= prodPipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      remQuo_q  <= '0;
      divisor_q <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      remQuo_q  <= remQuo_d;
      divisor_q <= divisor_d;
      negQuo_q  <= negQuo_d;
      negRem_q  <= negRem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    remQuo_d  = remQuo_q;
    divisor_d = divisor_q;
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dbz_d = 1'b0;
          cnt_d = '0;
          if (!bus.op[1]) begin
            state_d = ST_MUL;
          end else if (bus.b == 32'd0) begin
            state_d  = ST_DZ;
            remQuo_d = {32'b0, bus.a};
          end else begin
            state_d   = ST_DIV;
            negQuo_d  = divSigned & (bus.a[31] ^ bus.b[31]);
            negRem_d  = divSigned & bus.a[31];
            remQuo_d  = {32'b0, divSigned ? absVal(bus.a) : bus.a};
            divisor_d = divSigned ? absVal(bus.b) : bus.b;
          end
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      ST_MUL: begin
        if (cnt_q == 6'(MUL_LAT - 1)) begin
          {hi_d, lo_d} = prodPipe_q[MUL_LAT-1];
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DIV: begin
        remQuo_d = stepOut;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_STEPS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        lo_d    = negQuo_q ? -remQuo_q[31:0] : remQuo_q[31:0];
        hi_d    = negRem_q ? -remQuo_q[63:32] : remQuo_q[63:32];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_DZ: begin
        lo_d    = '1;
        hi_d    = remQuo_q[31:0];
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written corner sequences
// and random ops compared against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero as MIPS requires.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eHi, output logic [31:0] eLo,
                       output logic eDz, output int eLat);
    longint sa, sb, q, r, p;
    eDz = 1'b0;
    sa  = op[0] ? longint'($signed(a)) : longint'(a);
    sb  = op[0] ? longint'($signed(b)) : longint'(b);
    if (!op[1]) begin
      p    = sa * sb;
      eHi  = 32'(p >>> 32);
      eLo  = 32'(p);
      eLat = MUL_LAT;
    end else if (b == 32'd0) begin
      eHi  = a;
      eLo  = 32'hFFFF_FFFF;
      eDz  = 1'b1;
      eLat = 1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      eHi  = 32'(r);
      eLo  = 32'(q);
      eLat = 33;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic waitDone(input logic [31:0] oldHi, input logic [31:0] oldLo, inout int lat,
                          output bit seen, output bit holdBad);
    seen    = 1'b0;
    holdBad = 1'b0;
    while (!seen && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) seen = 1'b1;
      else if (bus.hi !== oldHi || bus.lo !== oldLo) holdBad = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] oldHi, input logic [31:0] oldLo,
                             input logic [31:0] eHi, input logic [31:0] eLo, input logic eDz,
                             input int eLat);
    int lat = 0;
    bit seen, holdBad;
    check({name, " busy"}, 64'(bus.busy), 64'd1);
    check({name, " dz_clear"}, 64'(bus.div_by_zero), 64'd0);
    waitDone(oldHi, oldLo, lat, seen, holdBad);
    check({name, " latency"}, 64'(lat), 64'(eLat));
    check({name, " hold"}, 64'(holdBad), 64'd0);
    check({name, " hi"}, 64'(bus.hi), 64'(eHi));
    check({name, " lo"}, 64'(bus.lo), 64'(eLo));
    check({name, " dz"}, 64'(bus.div_by_zero), 64'(eDz));
    check({name, " busy_done"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check({name, " single_done"}, 64'(bus.done), 64'd0);
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                       input logic eDz, input int eLat);
    logic [31:0] oldHi, oldLo;
    oldHi = bus.hi;
    oldLo = bus.lo;
    applyStimulus(op, a, b);
    checkOutput(name, oldHi, oldLo, eHi, eLo, eDz, eLat);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] eHi, eLo, oldHi, oldLo;
    logic        eDz;
    int          eLat, lat, doneCount;
    bit          seen, holdBad;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;

    vecs.push_back('{"multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 3});
    vecs.push_back('{"mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 3});
    vecs.push_back('{"multu_neg", 2'b00, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB, 1'b0, 3});
    vecs.push_back('{"div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33});
    vecs.push_back('{"divu_big",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 33});
    vecs.push_back('{"div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33});
    vecs.push_back('{"divu_zero", 2'b10, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1});
    vecs.push_back('{"div_pos",   2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 33});
    vecs.push_back('{"div_zero",  2'b11, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1});
    vecs.push_back('{"div_negb",  2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33});

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset dz", 64'(bus.div_by_zero), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);

    foreach (vecs[i])
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].expHi, vecs[i].expLo, vecs[i].expDz, vecs[i].expLat);

    // Second start plus MT writes while busy must all be dropped.
    runOp("clear_hilo", 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, MUL_LAT);
    applyStimulus(2'b00, 32'd6, 32'd7);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd100;
    bus.b     = 32'd3;
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    lat = 1;
    waitDone(32'd0, 32'd0, lat, seen, holdBad);
    check("busy_ignore latency", 64'(lat), 64'(MUL_LAT));
    check("busy_ignore hold", 64'(holdBad), 64'd0);
    check("busy_ignore hi", 64'(bus.hi), 64'd0);
    check("busy_ignore lo", 64'(bus.lo), 64'd42);
    @(posedge clk);
    #1;
    check("busy_ignore no_queue", 64'(bus.busy), 64'd0);

    // Idle MT writes land next edge without a done pulse.
    @(negedge clk);
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    check("mtlo lo", 64'(bus.lo), 64'h1234_5678);
    check("mtlo done", 64'(bus.done), 64'd0);
    @(negedge clk);
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0BAD_CAFE;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'h0BAD_CAFE);
    check("mthi lo_kept", 64'(bus.lo), 64'h1234_5678);

    // start wins over a same-cycle mthi.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    bus.mthi  = 1'b1;
    bus.wdata = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    check("start_vs_mthi hi_after_edge", 64'(bus.hi), 64'h0BAD_CAFE);
    lat = 0;
    waitDone(32'h0BAD_CAFE, 32'h1234_5678, lat, seen, holdBad);
    check("start_vs_mthi seen", 64'(seen), 64'd1);
    check("start_vs_mthi hi", 64'(bus.hi), 64'd0);
    check("start_vs_mthi lo", 64'(bus.lo), 64'd6);

    // Back-to-back: next start accepted in the done cycle.
    applyStimulus(2'b00, 32'd3, 32'd5);
    lat = 0;
    waitDone(32'd0, 32'd6, lat, seen, holdBad);
    check("b2b first lo", 64'(bus.lo), 64'd15);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd4;
    bus.b     = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b busy", 64'(bus.busy), 64'd1);
    lat = 0;
    waitDone(32'd0, 32'd15, lat, seen, holdBad);
    check("b2b latency", 64'(lat), 64'(MUL_LAT));
    check("b2b lo", 64'(bus.lo), 64'd20);

    // Reset mid-divide discards the op.
    applyStimulus(2'b11, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_div busy", 64'(bus.busy), 64'd0);
    check("rst_div done", 64'(bus.done), 64'd0);
    check("rst_div hi", 64'(bus.hi), 64'd0);
    check("rst_div lo", 64'(bus.lo), 64'd0);
    doneCount = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) doneCount++;
    end
    check("rst_div no_done", 64'(doneCount), 64'd0);
    runOp("after_rst", 2'b01, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0, MUL_LAT);

    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, eHi, eLo, eDz, eLat);
      runOp($sformatf("rand%0d", n), rop, ra, rb, eHi, eLo, eDz, eLat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
